// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard. Issue increments a small saturating
// counter for the destination register, write-back decrements it, and two
// source-operand queries report whether a register still has writes in flight.
module reg_scoreboard #(
  parameter int ADDR_W  = 5,
  parameter int NREG    = 32,
  parameter int CNT_W   = 2,
  parameter int ZERO_HW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iFlush,
  input  logic              iSetEna,
  input  logic [ADDR_W-1:0] iSetAddr,
  input  logic              iClrEna,
  input  logic [ADDR_W-1:0] iClrAddr,
  input  logic [ADDR_W-1:0] iRsAddr,
  input  logic [ADDR_W-1:0] iRtAddr,
  output logic              oRsBusy,
  output logic              oRtBusy,
  output logic              oSetStall,
  output logic [NREG-1:0]   oBusyVec,
  output logic              oErr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt     [NREG];
  logic             r_err;

  logic [CNT_W-1:0] w_cnt_nxt [NREG];
  logic [NREG-1:0]  w_set_dec;
  logic [NREG-1:0]  w_clr_dec;
  logic             w_set_ok;
  logic             w_clr_ok;
  logic             w_same;
  logic             w_stall;
  logic             w_underflow;

  // Qualify enables: with the hardwired zero register, traffic to r0 is dropped.
  always_comb begin
    w_set_ok = iSetEna;
    w_clr_ok = iClrEna;
    if ((ZERO_HW != 0) && (iSetAddr == '0)) w_set_ok = 1'b0;
    if ((ZERO_HW != 0) && (iClrAddr == '0)) w_clr_ok = 1'b0;
  end

  // One-hot decode of the set and clear addresses; a disabled port decodes to zero.
  always_comb begin
    w_set_dec = '0;
    w_clr_dec = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      w_set_dec[r] = w_set_ok && (iSetAddr == ADDR_W'(r));
      w_clr_dec[r] = w_clr_ok && (iClrAddr == ADDR_W'(r));
    end
  end

  // Hazard bookkeeping: same-register set+clear cancels, saturation refuses a set,
  // and a clear of an idle register flags an error.
  always_comb begin
    w_same      = iSetEna && iClrEna && (iSetAddr == iClrAddr);
    w_stall     = iSetEna && (r_cnt[iSetAddr] == CNT_MAX) && !w_same;
    w_underflow = w_clr_ok && !w_same && (r_cnt[iClrAddr] == '0);
  end

  // Next-count computation per register; counters never wrap in either direction.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      if (!w_same) begin
        if (w_set_dec[r] && !w_stall) begin
          w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
        end else if (w_clr_dec[r] && (r_cnt[r] != '0)) begin
          w_cnt_nxt[r] = r_cnt[r] - CNT_ONE;
        end
      end
    end
  end

  // State register: reset clears everything, flush clears counters but keeps the error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_err <= 1'b0;
    end else if (iFlush) begin
      for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= w_cnt_nxt[r];
      if (w_underflow) r_err <= 1'b1;
    end
  end

  // Busy vector straight from registered state.
  always_comb begin
    oBusyVec = '0;
    for (int unsigned r = 0; r < NREG; r++) oBusyVec[r] = (r_cnt[r] != '0);
  end

  // Queries and stall read registered state only; no same-cycle forwarding.
  always_comb begin
    oRsBusy   = (r_cnt[iRsAddr] != '0);
    oRtBusy   = (r_cnt[iRtAddr] != '0);
    oSetStall = w_stall;
    oErr      = r_err;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed table of cycles with hand-derived expected
// outputs, followed by a long randomized run against a count-array model.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst, iFlush, iSetEna, iClrEna;
  logic [4:0]  iSetAddr, iClrAddr, iRsAddr, iRtAddr;
  logic        oRsBusy, oRtBusy, oSetStall, oErr;
  logic [31:0] oBusyVec;

  int checks   = 0;
  int failures = 0;

  int mcnt [32];
  bit merr;

  reg_scoreboard #(.ADDR_W(5), .NREG(32), .CNT_W(2), .ZERO_HW(1)) dut (
    .clk(clk), .rst(rst), .iFlush(iFlush),
    .iSetEna(iSetEna), .iSetAddr(iSetAddr),
    .iClrEna(iClrEna), .iClrAddr(iClrAddr),
    .iRsAddr(iRsAddr), .iRtAddr(iRtAddr),
    .oRsBusy(oRsBusy), .oRtBusy(oRtBusy), .oSetStall(oSetStall),
    .oBusyVec(oBusyVec), .oErr(oErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rst, fl, se;
    bit [4:0]  sa;
    bit        ce;
    bit [4:0]  ca, rs, rt;
    bit        e_rs, e_rt, e_st, e_err;
    bit [31:0] e_vec;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit r, bit f, bit se, int sa, bit ce, int ca, int rs, int rt,
                              bit ers, bit ert, bit est, bit eerr, bit [31:0] evec);
    vec_t v;
    v.rst = r; v.fl = f; v.se = se; v.sa = 5'(sa); v.ce = ce; v.ca = 5'(ca);
    v.rs = 5'(rs); v.rt = 5'(rt);
    v.e_rs = ers; v.e_rt = ert; v.e_st = est; v.e_err = eerr; v.e_vec = evec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: 2-bit counters (max 3), r0 hardwired idle, spec rules in plain arithmetic.
  function automatic bit m_stall(bit se, int sa, bit ce, int ca);
    return se && (mcnt[sa] == 3) && !(ce && ca == sa);
  endfunction

  task automatic model_update(bit r, bit f, bit se, int sa, bit ce, int ca);
    bit same, stall;
    if (r) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      merr = 0;
    end else if (f) begin
      foreach (mcnt[i]) mcnt[i] = 0;
    end else begin
      same  = se && ce && (sa == ca);
      stall = m_stall(se, sa, ce, ca);
      if (!same) begin
        if (se && sa != 0 && !stall) mcnt[sa] = mcnt[sa] + 1;
        if (ce && ca != 0) begin
          if (mcnt[ca] > 0) mcnt[ca] = mcnt[ca] - 1;
          else merr = 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = (mcnt[i] != 0);
    return v;
  endfunction

  task automatic drive(bit r, bit f, bit se, int sa, bit ce, int ca, int rs, int rt);
    rst = r; iFlush = f; iSetEna = se; iSetAddr = 5'(sa);
    iClrEna = ce; iClrAddr = 5'(ca); iRsAddr = 5'(rs); iRtAddr = 5'(rt);
  endtask

  // One cycle checked against the model, then the edge.
  task automatic model_step(bit r, bit f, bit se, int sa, bit ce, int ca, int rs, int rt);
    drive(r, f, se, sa, ce, ca, rs, rt);
    #1;
    chk("busyvec", oBusyVec, m_vec());
    chk("rsbusy", 32'(oRsBusy), 32'(mcnt[rs] != 0));
    chk("rtbusy", 32'(oRtBusy), 32'(mcnt[rt] != 0));
    chk("setstall", 32'(oSetStall), 32'(m_stall(se, sa, ce, ca)));
    chk("err", 32'(oErr), 32'(merr));
    @(posedge clk);
    model_update(r, f, se, sa, ce, ca);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    foreach (mcnt[i]) mcnt[i] = 0;
    merr = 0;

    // Directed cycles; expected values are the outputs seen before that cycle's edge.
    //            rst fl se sa ce ca rs rt   rs rt st er vec
    tbl.push_back(mk(0,0, 1, 5, 0, 0, 5, 0,  0, 0, 0, 0, 32'h0));        // set r5
    tbl.push_back(mk(0,0, 0, 0, 0, 0, 5, 0,  1, 0, 0, 0, 32'h20));
    tbl.push_back(mk(0,0, 0, 0, 0, 0, 5, 0,  1, 0, 0, 0, 32'h20));
    tbl.push_back(mk(0,0, 0, 0, 1, 5, 5, 0,  1, 0, 0, 0, 32'h20));       // clr r5
    tbl.push_back(mk(0,0, 0, 0, 0, 0, 5, 0,  0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0,0, 1, 7, 0, 0, 0, 7,  0, 0, 0, 0, 32'h0));        // r7 -> 1
    tbl.push_back(mk(0,0, 1, 7, 0, 0, 0, 7,  0, 1, 0, 0, 32'h80));       // -> 2
    tbl.push_back(mk(0,0, 1, 7, 0, 0, 0, 7,  0, 1, 0, 0, 32'h80));       // -> 3
    tbl.push_back(mk(0,0, 1, 7, 0, 0, 0, 7,  0, 1, 1, 0, 32'h80));       // refused
    tbl.push_back(mk(0,0, 1, 7, 1, 7, 0, 7,  0, 1, 0, 0, 32'h80));       // set+clr at max
    tbl.push_back(mk(0,0, 1, 7, 0, 0, 0, 7,  0, 1, 1, 0, 32'h80));       // still 3
    tbl.push_back(mk(0,0, 0, 0, 1, 7, 0, 7,  0, 1, 0, 0, 32'h80));       // -> 2
    tbl.push_back(mk(0,0, 0, 0, 1, 7, 0, 7,  0, 1, 0, 0, 32'h80));       // -> 1
    tbl.push_back(mk(0,0, 0, 0, 1, 7, 0, 7,  0, 1, 0, 0, 32'h80));       // -> 0
    tbl.push_back(mk(0,0, 0, 0, 0, 0, 0, 7,  0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0,0, 0, 0, 1, 9, 9, 0,  0, 0, 0, 0, 32'h0));        // clr idle r9
    tbl.push_back(mk(0,0, 0, 0, 0, 0, 9, 0,  0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0,0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 32'h0));        // set r0
    tbl.push_back(mk(0,0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0,0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 32'h0));        // clr r0
    tbl.push_back(mk(0,0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(1,0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 32'h0));        // rst
    tbl.push_back(mk(0,0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 32'h0));        // clr r0, no err
    tbl.push_back(mk(0,0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0,0, 1, 3, 0, 0, 3, 12, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0,0, 1,12, 0, 0, 3, 12, 1, 0, 0, 0, 32'h8));
    tbl.push_back(mk(0,1, 1, 4, 0, 0, 3, 12, 1, 1, 0, 0, 32'h1008));     // flush + set r4
    tbl.push_back(mk(0,0, 0, 0, 0, 0, 3, 4,  0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0,0, 0, 0, 1, 9, 0, 0,  0, 0, 0, 0, 32'h0));        // raise err
    tbl.push_back(mk(0,0, 1, 3, 0, 0, 0, 0,  0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0,1, 0, 0, 0, 0, 3, 0,  1, 0, 0, 1, 32'h8));        // flush keeps err
    tbl.push_back(mk(0,0, 0, 0, 0, 0, 3, 0,  0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(1,0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0,1, 0, 0, 1, 9, 0, 0,  0, 0, 0, 0, 32'h0));        // flush drops clr
    tbl.push_back(mk(0,0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0,0, 1, 2, 0, 0, 2, 6,  0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0,0, 1, 6, 1, 2, 2, 6,  1, 0, 0, 0, 32'h4));        // set r6, clr r2
    tbl.push_back(mk(0,0, 1, 8, 1, 8, 2, 6,  0, 1, 0, 0, 32'h40));       // set+clr r8 at 0
    tbl.push_back(mk(0,0, 0, 0, 1, 6, 8, 6,  0, 1, 0, 0, 32'h40));
    tbl.push_back(mk(0,0, 0, 0, 0, 0, 8, 6,  0, 0, 0, 0, 32'h0));

    // Reset with random inputs for two cycles, then expect a clean state.
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      drive(1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 31)), 1'($urandom),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 5, 9);
    #1;
    chk("reset_busyvec", oBusyVec, 32'h0);
    chk("reset_err", 32'(oErr), 32'h0);
    chk("reset_rs", 32'(oRsBusy), 32'h0);
    chk("reset_rt", 32'(oRtBusy), 32'h0);
    chk("reset_stall", 32'(oSetStall), 32'h0);

    // Directed table; the model tracks along so the random run starts in sync.
    foreach (tbl[i]) begin
      vec_t v = tbl[i];
      drive(v.rst, v.fl, v.se, v.sa, v.ce, v.ca, v.rs, v.rt);
      #1;
      chk($sformatf("t%0d_busyvec", i), oBusyVec, v.e_vec);
      chk($sformatf("t%0d_rs", i), 32'(oRsBusy), 32'(v.e_rs));
      chk($sformatf("t%0d_rt", i), 32'(oRtBusy), 32'(v.e_rt));
      chk($sformatf("t%0d_stall", i), 32'(oSetStall), 32'(v.e_st));
      chk($sformatf("t%0d_err", i), 32'(oErr), 32'(v.e_err));
      @(posedge clk);
      model_update(v.rst, v.fl, v.se, v.sa, v.ce, v.ca);
      #1;
    end

    // Random run; addresses biased to a few registers so counters saturate often.
    for (int c = 0; c < 10000; c++) begin
      bit r, f, se, ce;
      int sa, ca, rs, rt;
      r  = ($urandom_range(0, 499) == 0) || (c == 5000);
      f  = ($urandom_range(0, 199) == 0);
      se = ($urandom_range(0, 99) < 60);
      ce = ($urandom_range(0, 99) < 45);
      sa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
      ca = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) ca = sa;
      rs = int'($urandom_range(0, 31));
      rt = int'($urandom_range(0, 3));
      model_step(r, f, se, sa, ce, ca, rs, rt);
      if (c == 5000) begin
        drive(0, 0, 0, 0, 0, 0, 1, 2);
        #1;
        chk("midreset_busyvec", oBusyVec, 32'h0);
        chk("midreset_err", 32'(oErr), 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
